// File: rtl/vpu_pkg.sv
// Shared VPU issue-stage types: instruction layout, exec request format,
// and the opcode decode / address-split helpers.
package vpu_pkg;

  localparam int REQ_W         = 136;
  localparam int ADDR_W        = 32;
  localparam int BANK_LG2      = 2;
  localparam int ROW_LG2       = 10;
  localparam int NSRC          = 3;
  localparam int OPC_W         = 8;
  localparam int MAX_DELAY_LG2 = 3;
  localparam int CNT_W         = 3;
  localparam int BANK_LSB      = 9;
  localparam int ROW_LSB       = BANK_LSB + BANK_LG2;

  typedef enum logic [OPC_W-1:0] {
    OPC_FADD  = 8'h01, OPC_FSUB  = 8'h02, OPC_FMUL  = 8'h03, OPC_FDIV  = 8'h04,
    OPC_FADD3 = 8'h05, OPC_FSUM  = 8'h06, OPC_FMAX  = 8'h07, OPC_FMAX2 = 8'h08,
    OPC_FMAX3 = 8'h09, OPC_FAVG2 = 8'h0A, OPC_FAVG3 = 8'h0B, OPC_FEXP  = 8'h0C
  } vpu_opcode_e;

  // src[0] occupies the low 32 bits, the opcode the top byte.
  typedef struct packed {
    logic [OPC_W-1:0]             opcode;
    logic [ADDR_W-1:0]            dst0;
    logic [NSRC-1:0][ADDR_W-1:0]  src;
  } vpu_h2d_req_instr_t;

  typedef struct packed {
    logic [MAX_DELAY_LG2-1:0] delay;
    logic [CNT_W-1:0]         src_cnt;
  } delay_and_src_cnt_t;

  typedef enum logic {OP_EXEC = 1'b0, OP_RED = 1'b1} vpu_op_type_e;

  typedef struct packed {
    logic fp_add, fp_sub, fp_mul, fp_div, fp_add3;
    logic fp_max2, fp_max3, fp_avg2, fp_avg3, fp_exp;
  } fp_req_t;

  typedef struct packed {
    logic                     fp_sum_r;
    logic                     fp_max_r;
    logic [MAX_DELAY_LG2-1:0] sub_delay;
  } red_req_t;

  typedef struct packed {
    vpu_op_type_e op_type;
    fp_req_t      fp;
    red_req_t     red;
  } vpu_exec_req_t;

  typedef enum logic [1:0] {S_IDLE, S_DEC, S_ISSUE} issue_state_e;

  function automatic logic is_legal_opcode(input logic [OPC_W-1:0] opcode);
    return (opcode >= OPC_FADD) && (opcode <= OPC_FEXP);
  endfunction

  function automatic delay_and_src_cnt_t get_delay_src_cnt(input logic [OPC_W-1:0] opcode);
    delay_and_src_cnt_t r;
    r = '0;
    case (opcode)
      OPC_FADD, OPC_FSUB, OPC_FMUL: r = '{delay: 3'd2, src_cnt: 3'd2};
      OPC_FDIV:                     r = '{delay: 3'd6, src_cnt: 3'd2};
      OPC_FADD3:                    r = '{delay: 3'd4, src_cnt: 3'd3};
      OPC_FSUM, OPC_FMAX:           r = '{delay: 3'd5, src_cnt: 3'd1};
      OPC_FMAX2:                    r = '{delay: 3'd1, src_cnt: 3'd2};
      OPC_FMAX3:                    r = '{delay: 3'd2, src_cnt: 3'd3};
      OPC_FAVG2:                    r = '{delay: 3'd3, src_cnt: 3'd2};
      OPC_FAVG3:                    r = '{delay: 3'd5, src_cnt: 3'd3};
      OPC_FEXP:                     r = '{delay: 3'd7, src_cnt: 3'd1};
      default:                      r = '0;
    endcase
    return r;
  endfunction

  // Reduction ops carry their latency in sub_delay; element-wise ops leave red_req clear.
  function automatic vpu_exec_req_t get_exec_req(input logic [OPC_W-1:0] opcode);
    vpu_exec_req_t r;
    r = '0;
    case (opcode)
      OPC_FADD:  r.fp.fp_add  = 1'b1;
      OPC_FSUB:  r.fp.fp_sub  = 1'b1;
      OPC_FMUL:  r.fp.fp_mul  = 1'b1;
      OPC_FDIV:  r.fp.fp_div  = 1'b1;
      OPC_FADD3: r.fp.fp_add3 = 1'b1;
      OPC_FMAX2: r.fp.fp_max2 = 1'b1;
      OPC_FMAX3: r.fp.fp_max3 = 1'b1;
      OPC_FAVG2: r.fp.fp_avg2 = 1'b1;
      OPC_FAVG3: r.fp.fp_avg3 = 1'b1;
      OPC_FEXP:  r.fp.fp_exp  = 1'b1;
      OPC_FSUM: begin
        r.op_type       = OP_RED;
        r.red.fp_sum_r  = 1'b1;
        r.red.sub_delay = get_delay_src_cnt(opcode).delay;
      end
      OPC_FMAX: begin
        r.op_type       = OP_RED;
        r.red.fp_max_r  = 1'b1;
        r.red.sub_delay = get_delay_src_cnt(opcode).delay;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [BANK_LG2-1:0] get_bank_id(input logic [ADDR_W-1:0] addr);
    return addr[ROW_LSB-1:BANK_LSB];
  endfunction

  function automatic logic [ROW_LG2-1:0] get_raddr(input logic [ADDR_W-1:0] addr);
    return addr[ROW_LSB+ROW_LG2-1:ROW_LSB];
  endfunction

  // Pending-source mask with bits 0..cnt-1 set.
  function automatic logic [NSRC-1:0] src_mask(input logic [CNT_W-1:0] cnt);
    logic [NSRC:0] m;
    m = (NSRC+1)'((1 << cnt) - 1);
    return m[NSRC-1:0];
  endfunction

endpackage

// File: rtl/vpu_bank_conflict_sched.sv
// Bank-conflict picker: grants pending sources in index order, at most one
// source per SRAM bank per cycle.
module vpu_bank_conflict_sched
  import vpu_pkg::*;
(
  input  logic [NSRC-1:0]          pend,
  input  logic [NSRC*BANK_LG2-1:0] bank,
  output logic [NSRC-1:0]          grant
);

  logic [(1<<BANK_LG2)-1:0] busy;

  // NOTE: blocking assignments here are intentional -- each loop iteration
  // must see the banks claimed by lower-indexed sources in the same evaluation.
  always_comb begin
    busy  = '0;
    grant = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pend[i] && !busy[bank[i*BANK_LG2 +: BANK_LG2]]) begin
        grant[i]                           = 1'b1;
        busy[bank[i*BANK_LG2 +: BANK_LG2]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vpu_instr_issue.sv
// VPU instruction issue stage: decodes one instruction, issues its SRAM
// source reads with bank-conflict serialisation, then hands metadata onward.
module vpu_instr_issue
  import vpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid_i,
  input  logic [REQ_W-1:0]           instr_i,
  output logic                       instr_ready_o,
  output logic [NSRC-1:0]            rd_en_o,
  output logic [NSRC*BANK_LG2-1:0]   rd_bank_o,
  output logic [NSRC*ROW_LG2-1:0]    rd_addr_o,
  input  logic                       op_ready_i,
  output logic                       op_valid_o,
  output logic [OPC_W-1:0]           op_opcode_o,
  output logic [CNT_W-1:0]           op_src_cnt_o,
  output logic [MAX_DELAY_LG2-1:0]   op_delay_o,
  output logic [15:0]                op_exec_req_o,
  output logic [BANK_LG2-1:0]        op_dst_bank_o,
  output logic [ROW_LG2-1:0]         op_dst_addr_o,
  output logic                       err_o
);

  issue_state_e                   state_q, state_d;
  logic                           ready_en_q;
  logic [NSRC-1:0]                pend_q, pend_d, grant;
  logic                           started_q, started_d;
  logic [OPC_W-1:0]               opcode_q;
  logic [NSRC-1:0][BANK_LG2-1:0]  src_bank_q;
  logic [NSRC-1:0][ROW_LG2-1:0]   src_row_q;
  logic [BANK_LG2-1:0]            dst_bank_q;
  logic [ROW_LG2-1:0]             dst_row_q;
  vpu_h2d_req_instr_t             instr;
  delay_and_src_cnt_t             dec;
  vpu_exec_req_t                  exec_req;
  logic                           accept;
  logic                           go;
  logic                           unused_addr_bits;

  assign instr         = instr_i;
  assign instr_ready_o = ready_en_q && (state_q == S_IDLE);
  assign accept        = instr_valid_i && instr_ready_o;
  assign dec           = get_delay_src_cnt(opcode_q);
  assign exec_req      = get_exec_req(opcode_q);
  // The operand-queue handshake only gates the first beat of an instruction.
  assign go            = op_ready_i || started_q;

  assign unused_addr_bits = ^{instr.dst0[ADDR_W-1:ROW_LSB+ROW_LG2], instr.dst0[BANK_LSB-1:0],
                              instr.src[0][ADDR_W-1:ROW_LSB+ROW_LG2], instr.src[0][BANK_LSB-1:0],
                              instr.src[1][ADDR_W-1:ROW_LSB+ROW_LG2], instr.src[1][BANK_LSB-1:0],
                              instr.src[2][ADDR_W-1:ROW_LSB+ROW_LG2], instr.src[2][BANK_LSB-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
      pend_q     <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      pend_q     <= pend_d;
      started_q  <= started_d;
    end
  end

  // NOTE: these datapath registers have no reset; every consumer is
  // qualified by the FSM state, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      opcode_q   <= instr.opcode;
      dst_bank_q <= get_bank_id(instr.dst0);
      dst_row_q  <= get_raddr(instr.dst0);
      for (int i = 0; i < NSRC; i++) begin
        src_bank_q[i] <= get_bank_id(instr.src[i]);
        src_row_q[i]  <= get_raddr(instr.src[i]);
      end
    end
  end

  vpu_bank_conflict_sched u_sched (
    .pend  (pend_q),
    .bank  (src_bank_q),
    .grant (grant)
  );

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    started_d     = started_q;
    rd_en_o       = '0;
    rd_bank_o     = '0;
    rd_addr_o     = '0;
    op_valid_o    = 1'b0;
    op_opcode_o   = '0;
    op_src_cnt_o  = '0;
    op_delay_o    = '0;
    op_exec_req_o = '0;
    op_dst_bank_o = '0;
    op_dst_addr_o = '0;
    err_o         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DEC;
      end
      S_DEC: begin
        started_d = 1'b0;
        if (!is_legal_opcode(opcode_q)) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          pend_d  = src_mask(dec.src_cnt);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (go) begin
          started_d = 1'b1;
          pend_d    = pend_q & ~grant;
          for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
              rd_en_o[i]                        = 1'b1;
              rd_bank_o[i*BANK_LG2 +: BANK_LG2] = src_bank_q[i];
              rd_addr_o[i*ROW_LG2 +: ROW_LG2]   = src_row_q[i];
            end
          end
          // Metadata travels with the final read beat.
          if (pend_d == '0) begin
            op_valid_o    = 1'b1;
            op_opcode_o   = opcode_q;
            op_src_cnt_o  = dec.src_cnt;
            op_delay_o    = dec.delay;
            op_exec_req_o = exec_req;
            op_dst_bank_o = dst_bank_q;
            op_dst_addr_o = dst_row_q;
            state_d       = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
